fc_ibuf_slice: RTL and testbench

//  Double-buffered (ping-pong) input buffer for an FC layer. Sits between the previous layer's output buffer and this layer's CIM crossbar drivers.

---
 rtl/fc_ibuf_pkg.sv | 41 ++++
 rtl/fc_ibuf_bank.sv | 66 ++++++
 rtl/fc_ibuf_slice.sv | 157 +++++++++++++++
 tb/tb_fc_ibuf_slice.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fc_ibuf_pkg.sv
// ============================================================================
// Module   : fc_ibuf_pkg
// Purpose  : Shared types and sizing helpers for the FC-layer ping-pong input
//            buffer (fc_ibuf_slice / fc_ibuf_bank).
// Contents : bank_sel_t, safe_clog2, calc_num_slices, calc_num_addr,
//            slice_cfg_ok
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fc_ibuf_pkg;

  // Selects one of the two ping-pong banks.
  typedef logic bank_sel_t;

  // $clog2 that never returns 0, so single-entry selectors still get a
  // 1-bit port.
  function automatic int safe_clog2(input int value);
    int r;
    r = $clog2(value);
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int calc_num_slices(input int data_size, input int slice_bits);
    return data_size / slice_bits;
  endfunction

  // Number of OUT_W-wide windows needed to cover one flattened slice.
  function automatic int calc_num_addr(input int vec_elems, input int slice_bits,
                                       input int out_w);
    return (vec_elems * slice_bits + out_w - 1) / out_w;
  endfunction

  // Slicing only works when every element splits into whole slices.
  function automatic bit slice_cfg_ok(input int data_size, input int slice_bits);
    return (slice_bits > 0) && ((data_size % slice_bits) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fc_ibuf_bank.sv
// ============================================================================
// Module   : fc_ibuf_bank
// Purpose  : Storage for one input vector. Written one beat at a time, read
//            as a flat bit-slice selected by the slice index (non-destructive).
// Ports    : clk, rst          clock / async active-high reset
//            i_we              write the beat at i_beat
//            i_beat            beat index of the write
//            i_data            IN_CHANNELS elements of DATA_SIZE bits
//            i_slice_idx       which SLICE_BITS-wide slice of each element
//            o_flat            VEC_ELEMS*SLICE_BITS bits, element 0 in LSBs
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_ibuf_bank
  import fc_ibuf_pkg::*;
#(
  parameter  int DATA_SIZE   = 8,
  parameter  int IN_CHANNELS = 16,
  parameter  int FIFO_LENGTH = 8,
  parameter  int SLICE_BITS  = 1,
  localparam int NUM_SLICES  = calc_num_slices(DATA_SIZE, SLICE_BITS),
  localparam int BEAT_W      = safe_clog2(FIFO_LENGTH),
  localparam int SLICE_W     = safe_clog2(NUM_SLICES),
  localparam int FLAT_W      = FIFO_LENGTH * IN_CHANNELS * SLICE_BITS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_we,
  input  logic [BEAT_W-1:0]                   i_beat,
  input  logic [IN_CHANNELS-1:0][DATA_SIZE-1:0] i_data,
  input  logic [SLICE_W-1:0]                  i_slice_idx,
  output logic [FLAT_W-1:0]                   o_flat
);

  logic [IN_CHANNELS-1:0][DATA_SIZE-1:0] r_mem [FIFO_LENGTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_LENGTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_beat] <= i_data;
    end
  end

  // Slice selection is written as a compare-per-slice mux so every part
  // select uses constant indices.
  always_comb begin
    o_flat = '0;
    for (int s = 0; s < NUM_SLICES; s++) begin
      if (i_slice_idx == SLICE_W'(s)) begin
        for (int bt = 0; bt < FIFO_LENGTH; bt++) begin
          for (int ch = 0; ch < IN_CHANNELS; ch++) begin
            o_flat[(bt*IN_CHANNELS + ch)*SLICE_BITS +: SLICE_BITS] =
              r_mem[bt][ch][s*SLICE_BITS +: SLICE_BITS];
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fc_ibuf_slice.sv
// ============================================================================
// Module   : fc_ibuf_slice
// Purpose  : Ping-pong input buffer for an FC layer. One bank fills from
//            IN_CHANNELS-wide beats while the other is presented bit-sliced
//            to the CIM crossbar bus.
// Ports    : clk, rst          clock / async active-high reset
//            i_valid, o_ready  write beat handshake
//            i_data            write beat elements
//            o_vec_valid       read bank holds a complete vector
//            i_se              advance to next slice (saturating)
//            i_release         free the read bank, restart at slice 0
//            i_ibuf_addr       OUT_W window select
//            o_data            slice window (combinational)
//            o_slice_idx       current slice index
//            o_last_slice      on the final slice of a valid vector
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_ibuf_slice
  import fc_ibuf_pkg::*;
#(
  parameter  int DATA_SIZE       = 8,
  parameter  int IN_CHANNELS     = 16,
  parameter  int FIFO_LENGTH     = 8,
  parameter  int SLICE_BITS      = 1,
  parameter  int BUS_WIDTH       = 16,
  parameter  int V_CIM_TILES_OUT = 1,
  localparam int VEC_ELEMS       = FIFO_LENGTH * IN_CHANNELS,
  localparam int OUT_W           = BUS_WIDTH * V_CIM_TILES_OUT,
  localparam int NUM_SLICES      = calc_num_slices(DATA_SIZE, SLICE_BITS),
  localparam int NUM_ADDR        = calc_num_addr(VEC_ELEMS, SLICE_BITS, OUT_W),
  localparam int ADDR_W          = safe_clog2(NUM_ADDR),
  localparam int SLICE_W         = safe_clog2(NUM_SLICES)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_valid,
  output logic                                  o_ready,
  input  logic [IN_CHANNELS-1:0][DATA_SIZE-1:0] i_data,
  output logic                                  o_vec_valid,
  input  logic                                  i_se,
  input  logic                                  i_release,
  input  logic [ADDR_W-1:0]                     i_ibuf_addr,
  output logic [OUT_W-1:0]                      o_data,
  output logic [SLICE_W-1:0]                    o_slice_idx,
  output logic                                  o_last_slice
);

  localparam int C_FLAT_W = VEC_ELEMS * SLICE_BITS;
  localparam int C_PAD_W  = NUM_ADDR * OUT_W;
  localparam int C_BEAT_W = safe_clog2(FIFO_LENGTH);
  localparam logic [C_BEAT_W-1:0] C_LAST_BEAT  = C_BEAT_W'(FIFO_LENGTH - 1);
  localparam logic [SLICE_W-1:0]  C_LAST_SLICE = SLICE_W'(NUM_SLICES - 1);

  if (!slice_cfg_ok(DATA_SIZE, SLICE_BITS)) begin : g_bad_cfg
    $error("fc_ibuf_slice: SLICE_BITS must divide DATA_SIZE");
  end

  logic [1:0]          r_full;
  bank_sel_t           r_wr_bank;
  bank_sel_t           r_rd_bank;
  logic [C_BEAT_W-1:0] r_beat;
  logic [SLICE_W-1:0]  r_slice_idx;

  logic                w_wr_fire;
  logic                w_last_beat;
  logic                w_release;
  logic                w_se_adv;
  logic [1:0]          w_full_nxt;
  logic [C_FLAT_W-1:0] w_bank_flat [2];
  logic [C_PAD_W-1:0]  w_padded;

  assign o_ready      = !r_full[r_wr_bank];
  assign o_vec_valid  = r_full[r_rd_bank];
  assign o_slice_idx  = r_slice_idx;
  assign o_last_slice = o_vec_valid && (r_slice_idx == C_LAST_SLICE);

  assign w_wr_fire   = i_valid && o_ready;
  assign w_last_beat = w_wr_fire && (r_beat == C_LAST_BEAT);
  assign w_release   = i_release && o_vec_valid;
  // Release has priority; advance saturates on the last slice.
  assign w_se_adv    = i_se && o_vec_valid && !i_release &&
                       (r_slice_idx != C_LAST_SLICE);

  // Completion and release can coincide; they always hit different banks
  // (one must be empty to be written, the other full to be released).
  always_comb begin
    w_full_nxt = r_full;
    if (w_last_beat) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_release)   w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full      <= '0;
      r_wr_bank   <= '0;
      r_rd_bank   <= '0;
      r_beat      <= '0;
      r_slice_idx <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr_fire) begin
        if (w_last_beat) begin
          r_beat    <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_beat <= r_beat + 1'b1;
        end
      end
      if (w_release) begin
        r_rd_bank   <= ~r_rd_bank;
        r_slice_idx <= '0;
      end else if (w_se_adv) begin
        r_slice_idx <= r_slice_idx + 1'b1;
      end
    end
  end

  for (genvar gb = 0; gb < 2; gb++) begin : g_bank
    fc_ibuf_bank #(
      .DATA_SIZE   (DATA_SIZE),
      .IN_CHANNELS (IN_CHANNELS),
      .FIFO_LENGTH (FIFO_LENGTH),
      .SLICE_BITS  (SLICE_BITS)
    ) u_bank (
      .clk         (clk),
      .rst         (rst),
      .i_we        (w_wr_fire && (r_wr_bank == bank_sel_t'(gb))),
      .i_beat      (r_beat),
      .i_data      (i_data),
      .i_slice_idx (r_slice_idx),
      .o_flat      (w_bank_flat[gb])
    );
  end

  // Zero-extend the read bank's flat slice to a whole number of windows.
  always_comb begin
    w_padded                 = '0;
    w_padded[C_FLAT_W-1:0]   = w_bank_flat[r_rd_bank];
  end

  // Addresses at or above NUM_ADDR match no window and so return zero.
  always_comb begin
    o_data = '0;
    if (o_vec_valid) begin
      for (int a = 0; a < NUM_ADDR; a++) begin
        if (i_ibuf_addr == ADDR_W'(a)) begin
          o_data = w_padded[a*OUT_W +: OUT_W];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fc_ibuf_slice.sv
// ============================================================================
// Module   : tb_fc_ibuf_slice
// Purpose  : Directed self-checking bench for fc_ibuf_slice. A 1-bit-slice
//            instance covers fill, slicing, ping-pong and reset; a 2-bit-slice
//            instance with a 3-window bus covers multi-bit slices, padding and
//            out-of-range addressing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fc_ibuf_slice;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance: 8-bit data, 4 channels, 2 beats, 1-bit slices, 4-bit bus.
  logic            valid, ready, vv, se, rel, last;
  logic [3:0][7:0] din;
  logic [0:0]      addr;
  logic [3:0]      dout;
  logic [2:0]      idx;

  // Second instance: 2-bit slices, 6-bit bus -> NUM_ADDR=3, 2-bit address.
  logic            valid2, ready2, vv2, se2, rel2, last2;
  logic [3:0][7:0] din2;
  logic [1:0]      addr2;
  logic [5:0]      dout2;
  logic [1:0]      idx2;

  fc_ibuf_slice #(
    .DATA_SIZE(8), .IN_CHANNELS(4), .FIFO_LENGTH(2),
    .SLICE_BITS(1), .BUS_WIDTH(4), .V_CIM_TILES_OUT(1)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(valid), .o_ready(ready), .i_data(din),
    .o_vec_valid(vv), .i_se(se), .i_release(rel), .i_ibuf_addr(addr),
    .o_data(dout), .o_slice_idx(idx), .o_last_slice(last)
  );

  fc_ibuf_slice #(
    .DATA_SIZE(8), .IN_CHANNELS(4), .FIFO_LENGTH(2),
    .SLICE_BITS(2), .BUS_WIDTH(6), .V_CIM_TILES_OUT(1)
  ) dut2 (
    .clk(clk), .rst(rst), .i_valid(valid2), .o_ready(ready2), .i_data(din2),
    .o_vec_valid(vv2), .i_se(se2), .i_release(rel2), .i_ibuf_addr(addr2),
    .o_data(dout2), .o_slice_idx(idx2), .o_last_slice(last2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_beat(input logic [7:0] e0, e1, e2, e3);
    valid = 1'b1;
    din   = {e3, e2, e1, e0};
    tick();
    valid = 1'b0;
  endtask

  task automatic wr_beat2(input logic [7:0] e0, e1, e2, e3);
    valid2 = 1'b1;
    din2   = {e3, e2, e1, e0};
    tick();
    valid2 = 1'b0;
  endtask

  task automatic chk_data(input string tag, input logic [0:0] a, input logic [3:0] exp);
    addr = a;
    #1;
    check(tag, 32'(dout), 32'(exp));
  endtask

  task automatic chk_data2(input string tag, input logic [1:0] a, input logic [5:0] exp);
    addr2 = a;
    #1;
    check(tag, 32'(dout2), 32'(exp));
  endtask

  initial begin
    rst = 1'b1;
    valid = 1'b0; din = '0; se = 1'b0; rel = 1'b0; addr = '0;
    valid2 = 1'b0; din2 = '0; se2 = 1'b0; rel2 = 1'b0; addr2 = '0;

    // ---- reset state ----
    repeat (2) tick();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_vv",    32'(vv),    32'd0);
    check("rst_data",  32'(dout),  32'd0);
    rst = 1'b0;
    tick();
    check("rst_idx",   32'(idx),   32'd0);
    check("rst_last",  32'(last),  32'd0);

    // ---- fill vector A, slice 0 and 1 ----
    wr_beat(8'd1, 8'd2, 8'd3, 8'd4);
    check("A_vv_partial", 32'(vv), 32'd0);
    wr_beat(8'd5, 8'd6, 8'd7, 8'd8);
    check("A_vv",    32'(vv),    32'd1);
    check("A_ready", 32'(ready), 32'd1);
    chk_data("A_s0_a0", 1'b0, 4'b0101);
    chk_data("A_s0_a1", 1'b1, 4'b0101);
    se = 1'b1; tick(); se = 1'b0;
    check("A_idx1", 32'(idx), 32'd1);
    chk_data("A_s1_a0", 1'b0, 4'b0110);
    chk_data("A_s1_a1", 1'b1, 4'b0110);

    // ---- ping-pong: fill B while A is read, extra beat dropped ----
    wr_beat(8'h0E, 8'h0F, 8'h0E, 8'h0F);
    wr_beat(8'hFF, 8'h00, 8'hFF, 8'h00);
    check("B_ready_full", 32'(ready), 32'd0);
    check("B_vv",         32'(vv),    32'd1);
    wr_beat(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    check("drop_ready",   32'(ready), 32'd0);
    chk_data("drop_A_intact", 1'b0, 4'b0110);
    check("drop_idx",     32'(idx),   32'd1);
    rel = 1'b1; tick(); rel = 1'b0;
    check("rel_ready", 32'(ready), 32'd1);
    check("rel_vv",    32'(vv),    32'd1);
    check("rel_idx",   32'(idx),   32'd0);
    chk_data("B_s0_a0", 1'b0, 4'b1010);
    chk_data("B_s0_a1", 1'b1, 4'b0101);

    // ---- slice saturation and se+release ----
    se = 1'b1;
    repeat (6) tick();
    check("sat_idx6",  32'(idx),  32'd6);
    check("sat_last6", 32'(last), 32'd0);
    tick();
    check("sat_idx7",  32'(idx),  32'd7);
    check("sat_last7", 32'(last), 32'd1);
    chk_data("B_s7_a0", 1'b0, 4'b0000);
    chk_data("B_s7_a1", 1'b1, 4'b0101);
    tick();
    se = 1'b0;
    check("sat_hold", 32'(idx), 32'd7);
    se = 1'b1; rel = 1'b1; tick(); se = 1'b0; rel = 1'b0;
    check("serel_idx",   32'(idx),   32'd0);
    check("serel_vv",    32'(vv),    32'd0);
    check("serel_ready", 32'(ready), 32'd1);
    check("serel_last",  32'(last),  32'd0);
    chk_data("serel_data", 1'b1, 4'b0000);
    se = 1'b1; tick(); se = 1'b0;
    check("se_idle_idx", 32'(idx), 32'd0);

    // ---- async reset mid-fill / mid-slice ----
    wr_beat(8'd1, 8'd2, 8'd3, 8'd4);
    wr_beat(8'd5, 8'd6, 8'd7, 8'd8);
    wr_beat(8'd9, 8'd9, 8'd9, 8'd9);
    se = 1'b1; tick(); se = 1'b0;
    chk_data("pre_rst_data", 1'b0, 4'b0110);
    rst = 1'b1;
    #1;
    check("arst_vv",    32'(vv),    32'd0);
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_data",  32'(dout),  32'd0);
    check("arst_idx",   32'(idx),   32'd0);
    check("arst_last",  32'(last),  32'd0);
    tick();
    rst = 1'b0;

    // ---- reset after one beat, then a fresh vector starts at beat 0 ----
    wr_beat(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    rst = 1'b1; tick(); rst = 1'b0;
    wr_beat(8'd1, 8'd2, 8'd3, 8'd4);
    check("fresh_vv_partial", 32'(vv), 32'd0);
    wr_beat(8'd5, 8'd6, 8'd7, 8'd8);
    check("fresh_vv", 32'(vv), 32'd1);
    chk_data("fresh_s0_a0", 1'b0, 4'b0101);
    chk_data("fresh_s0_a1", 1'b1, 4'b0101);

    // ---- last beat and release in the same cycle ----
    wr_beat(8'h0E, 8'h0F, 8'h0E, 8'h0F);
    valid = 1'b1; din = {8'h00, 8'hFF, 8'h00, 8'hFF}; rel = 1'b1;
    tick();
    valid = 1'b0; rel = 1'b0;
    check("both_vv",    32'(vv),    32'd1);
    check("both_ready", 32'(ready), 32'd1);
    chk_data("both_s0_a0", 1'b0, 4'b1010);
    chk_data("both_s0_a1", 1'b1, 4'b0101);

    // ---- 2-bit slices, padding, out-of-range address ----
    wr_beat2(8'hB4, 8'hFF, 8'h00, 8'h00);
    wr_beat2(8'h00, 8'h00, 8'hFF, 8'hFF);
    check("s2_vv", 32'(vv2), 32'd1);
    chk_data2("s2_sl0_a0", 2'd0, 6'b001100);
    chk_data2("s2_sl0_a2", 2'd2, 6'b001111);
    chk_data2("s2_sl0_a3", 2'd3, 6'b000000);
    se2 = 1'b1; tick(); se2 = 1'b0;
    chk_data2("s2_sl1_a0", 2'd0, 6'b001101);
    se2 = 1'b1; tick(); se2 = 1'b0;
    chk_data2("s2_sl2_a0", 2'd0, 6'b001111);
    se2 = 1'b1; tick(); se2 = 1'b0;
    chk_data2("s2_sl3_a0", 2'd0, 6'b001110);
    check("s2_idx3",  32'(idx2),  32'd3);
    check("s2_last3", 32'(last2), 32'd1);
    chk_data2("s2_sl3_a1", 2'd1, 6'b000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
